// File: rtl/audio_i2s_out.sv
// I2S output stage: mixes PSG + PCM per channel with 16-bit saturation once per
// frame and shifts the pair out MSB first in 32-bit slots. Optional: AUDIO_I2S_OUT_MUTE_EN.
module audio_i2s_out #(
  parameter int CLK_PER_BCK = 8
) (
  input  logic               clk,
  input  logic               rst_n,
`ifdef AUDIO_I2S_OUT_MUTE_EN
  input  logic               mute,
`endif
  input  logic signed [15:0] psg_left,
  input  logic signed [15:0] psg_right,
  input  logic signed [15:0] pcm_left,
  input  logic signed [15:0] pcm_right,
  output logic               next_sample,
  output logic               i2s_bck,
  output logic               i2s_lrck,
  output logic               i2s_data
);

  localparam int DIV_W = (CLK_PER_BCK > 2) ? $clog2(CLK_PER_BCK) : 1;

  logic [DIV_W-1:0]   div_q, div_d;
  logic [5:0]         bit_q, bit_d;
  logic signed [15:0] hold_l_q, hold_l_d;
  logic signed [15:0] hold_r_q, hold_r_d;
  logic               next_sample_q, next_sample_d;
  logic               bck_q, bck_d;
  logic               lrck_q, lrck_d;
  logic               data_q, data_d;

  logic               frame_start;
  logic               div_wrap;
  logic signed [16:0] sum_l, sum_r;
  logic signed [15:0] word;
  logic [4:0]         slot;
  logic [3:0]         idx;

  function automatic logic signed [15:0] sat16(input logic signed [16:0] v);
    if (v > 17'sd32767)       return 16'sh7FFF;
    else if (v < -17'sd32768) return 16'sh8000;
    else                      return v[15:0];
  endfunction

  always_comb begin
    div_wrap    = (div_q == DIV_W'(CLK_PER_BCK - 1));
    frame_start = (div_q == '0) && (bit_q == '0);
    div_d       = div_wrap ? '0 : div_q + 1'b1;
    bit_d       = div_wrap ? bit_q + 1'b1 : bit_q;

    sum_l = psg_left + pcm_left;
    sum_r = psg_right + pcm_right;
    hold_l_d = hold_l_q;
    hold_r_d = hold_r_q;
    if (frame_start) begin
`ifdef AUDIO_I2S_OUT_MUTE_EN
      hold_l_d = mute ? 16'sd0 : sat16(sum_l);
      hold_r_d = mute ? 16'sd0 : sat16(sum_r);
`else
      hold_l_d = sat16(sum_l);
      hold_r_d = sat16(sum_r);
`endif
    end
    next_sample_d = frame_start;
  end

  // Serial outputs: registered straight from counter state, one clock behind it
  always_comb begin
    bck_d  = (div_q >= DIV_W'(CLK_PER_BCK / 2));
    lrck_d = bit_q[5];
    slot   = bit_q[4:0];
    word   = bit_q[5] ? hold_r_q : hold_l_q;
    idx    = 4'(5'd16 - slot);
    data_d = ((slot >= 5'd1) && (slot <= 5'd16)) ? word[idx] : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q         <= '0;
      bit_q         <= '0;
      hold_l_q      <= '0;
      hold_r_q      <= '0;
      next_sample_q <= 1'b0;
      bck_q         <= 1'b0;
      lrck_q        <= 1'b0;
      data_q        <= 1'b0;
    end else begin
      div_q         <= div_d;
      bit_q         <= bit_d;
      hold_l_q      <= hold_l_d;
      hold_r_q      <= hold_r_d;
      next_sample_q <= next_sample_d;
      bck_q         <= bck_d;
      lrck_q        <= lrck_d;
      data_q        <= data_d;
    end
  end

  assign next_sample = next_sample_q;
  assign i2s_bck     = bck_q;
  assign i2s_lrck    = lrck_q;
  assign i2s_data    = data_q;

endmodule

// File: tb/tb_audio_i2s_out.sv
// Randomized and directed bench for audio_i2s_out against a frame-position
// reference model; serial words are reassembled at i2s_bck rising edges.
module tb_audio_i2s_out;

  localparam int CPB   = 8;
  localparam int FRAME = 64 * CPB;

  logic        clk;
  logic        rst_n;
  logic        mute;
  logic [15:0] psg_left, psg_right, pcm_left, pcm_right;
  logic        next_sample, i2s_bck, i2s_lrck, i2s_data;

  int total = 0;
  int bad   = 0;

  // reference model state
  int pos = 0;
  int ml  = 0;
  int mr  = 0;
  logic [31:0] cap_l, cap_r;

  audio_i2s_out #(.CLK_PER_BCK(CPB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef AUDIO_I2S_OUT_MUTE_EN
    .mute       (mute),
`endif
    .psg_left   (psg_left),
    .psg_right  (psg_right),
    .pcm_left   (pcm_left),
    .pcm_right  (pcm_right),
    .next_sample(next_sample),
    .i2s_bck    (i2s_bck),
    .i2s_lrck   (i2s_lrck),
    .i2s_data   (i2s_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int mix(input logic [15:0] a, input logic [15:0] b, input logic m);
    int s;
    s = int'($signed(a)) + int'($signed(b));
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    return m ? 0 : (s & 32'hFFFF);
  endfunction

  // One clock: advance the model with what the DUT sampled, then compare outputs.
  task automatic step();
    int n, b, s, w, d;
    logic [3:0] exp;
    @(posedge clk);
    n = -1;
    if (!rst_n) begin
      pos = 0; ml = 0; mr = 0;
      exp = 4'b0000;
    end else begin
`ifdef AUDIO_I2S_OUT_MUTE_EN
      if (pos == 0) begin ml = mix(psg_left, pcm_left, mute); mr = mix(psg_right, pcm_right, mute); end
`else
      if (pos == 0) begin ml = mix(psg_left, pcm_left, 1'b0); mr = mix(psg_right, pcm_right, 1'b0); end
`endif
      n = pos;
      b = n / CPB;
      s = b % 32;
      w = (b >= 32) ? mr : ml;
      d = (s >= 1 && s <= 16) ? ((w >> (16 - s)) & 1) : 0;
      exp = {n == 0, (n % CPB) >= CPB / 2, b >= 32, d != 0};
      pos = (pos + 1) % FRAME;
    end
    #1;
    check_val("outs{ns,bck,lrck,data}", {28'd0, next_sample, i2s_bck, i2s_lrck, i2s_data}, {28'd0, exp});
    if (n >= 0 && (n % CPB) == CPB / 2) begin
      b = n / CPB;
      if (b < 32) cap_l[31 - b] = i2s_data;
      else        cap_r[31 - (b - 32)] = i2s_data;
    end
  endtask

  task automatic run_steps(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic check_frame(input string tag, input logic [15:0] el, input logic [15:0] er);
    check_val({tag, "_l"}, {16'd0, cap_l[30:15]}, {16'd0, el});
    check_val({tag, "_r"}, {16'd0, cap_r[30:15]}, {16'd0, er});
    check_val({tag, "_pad"}, {cap_l[31], cap_l[14:0], cap_r[31], cap_r[14:0]}, 32'd0);
  endtask

  initial begin
    logic [15:0] el, er;
    rst_n = 1'b0; mute = 1'b0;
    psg_left = 16'h8001; psg_right = 16'h1234; pcm_left = 16'h0000; pcm_right = 16'h0000;
    cap_l = '1; cap_r = '1;

    // reset held 5 clocks, outputs all zero
    run_steps(5);
    check_val("reset_outs", {28'd0, next_sample, i2s_bck, i2s_lrck, i2s_data}, 32'd0);
    rst_n = 1'b1;
    step();
    check_val("ns_first_cycle", {31'd0, next_sample}, 32'd1);
    run_steps(FRAME - 1);
    check_frame("serial", 16'h8001, 16'h1234);

    // saturation
    psg_left = 16'h7000; pcm_left = 16'h2000; psg_right = 16'h9000; pcm_right = 16'h9000;
    run_steps(FRAME);
    check_frame("sat_pos_neg", 16'h7FFF, 16'h8000);
    psg_left = 16'h0100; pcm_left = 16'hFF00; psg_right = 16'h7FFF; pcm_right = 16'h0001;
    run_steps(FRAME);
    check_frame("sat_zero", 16'h0000, 16'h7FFF);

    // mid-frame input change only lands at the next frame
    psg_left = 16'hAAAA; pcm_left = 16'h0000; psg_right = 16'h0F0F; pcm_right = 16'h0000;
    run_steps(5 * CPB);
    psg_left = 16'h5555;
    run_steps(FRAME - 5 * CPB);
    check_frame("midchg_cur", 16'hAAAA, 16'h0F0F);
    run_steps(FRAME);
    check_frame("midchg_next", 16'h5555, 16'h0F0F);

    // random frames with random mid-frame disturbance
    for (int f = 0; f < 6; f++) begin
      psg_left = 16'($urandom); pcm_left = 16'($urandom);
      psg_right = 16'($urandom); pcm_right = 16'($urandom);
      el = 16'(mix(psg_left, pcm_left, 1'b0));
      er = 16'(mix(psg_right, pcm_right, 1'b0));
      run_steps($urandom_range(1, FRAME - 1));
      psg_left = 16'($urandom); pcm_right = 16'($urandom);
      while (pos != 0) step();
      check_frame("rand", el, er);
    end

    // reset mid-frame at bit 40
    run_steps(40 * CPB);
    rst_n = 1'b0;
    step();
    check_val("midrst_outs", {28'd0, next_sample, i2s_bck, i2s_lrck, i2s_data}, 32'd0);
    rst_n = 1'b1;
    psg_left = 16'h0001; pcm_left = 16'h0002; psg_right = 16'hFFFF; pcm_right = 16'h0000;
    step();
    check_val("midrst_ns", {31'd0, next_sample}, 32'd1);
    run_steps(FRAME - 1);
    check_frame("midrst_frame", 16'h0003, 16'hFFFF);

`ifdef AUDIO_I2S_OUT_MUTE_EN
    psg_left = 16'h1357; psg_right = 16'h2468; pcm_left = 16'h0000; pcm_right = 16'h0000;
    run_steps(FRAME);
    check_frame("premute", 16'h1357, 16'h2468);
    run_steps(20 * CPB);
    mute = 1'b1;
    run_steps(FRAME - 20 * CPB);
    check_frame("mute_cur", 16'h1357, 16'h2468);
    step();
    check_val("mute_ns", {31'd0, next_sample}, 32'd1);
    run_steps(FRAME - 1);
    check_frame("mute_next", 16'h0000, 16'h0000);
    mute = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
